// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - Ascon-128a shared constants, phase encoding and helpers
package ascon_pkg;

    localparam logic [63:0]  IV           = 64'h80800c0800000000;
    localparam int           DEF_ROUNDS_A = 12;
    localparam int           DEF_ROUNDS_B = 8;
    localparam logic [127:0] PAD128       = {8'h80, 120'h0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ADATA,
        ST_APAD,
        ST_CDATA,
        ST_FINAL
    } phase_e;

    // idx is the position within the full 12-round schedule (0..11)
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return 8'hf0 - ({4'h0, idx} * 8'h0f);
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon permutation round (pc, ps, pl)
module ascon_round
    import ascon_pkg::*;
(
    input  logic [319:0] s_i,
    input  logic [7:0]   rc_i,
    output logic [319:0] s_o
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    assign x0 = s_i[319:256];
    assign x1 = s_i[255:192];
    assign x2 = s_i[191:128] ^ {56'h0, rc_i};
    assign x3 = s_i[127:64];
    assign x4 = s_i[63:0];

    // Bitsliced 5-bit S-box: input mix, chi, output mix
    assign a0 = x0 ^ x4;
    assign a1 = x1;
    assign a2 = x2 ^ x1;
    assign a3 = x3;
    assign a4 = x4 ^ x3;

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign c0 = b0 ^ b4;
    assign c1 = b1 ^ b0;
    assign c2 = ~b2;
    assign c3 = b3 ^ b2;
    assign c4 = b4;

    assign s_o[319:256] = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
    assign s_o[255:192] = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
    assign s_o[191:128] = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
    assign s_o[127:64]  = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
    assign s_o[63:0]    = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);

endmodule

// File: rtl/decrypt_1block_128a.sv
// rtl/decrypt_1block_128a.sv - iterative Ascon-128a one-block decryptor with tag check
module decrypt_1block_128a
    import ascon_pkg::*;
#(
    parameter int ROUNDS_A = DEF_ROUNDS_A,
    parameter int ROUNDS_B = DEF_ROUNDS_B,
    parameter bit GATE_PT  = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [127:0] SK,
    input  logic [127:0] N,
    input  logic [127:0] A,
    input  logic [127:0] C,
    input  logic [127:0] T,
    output logic         busy,
    output logic         done,
    output logic [127:0] P,
    output logic         tag_ok
);

    localparam int            CW     = $clog2(ROUNDS_A);
    localparam logic [CW-1:0] LAST_A = CW'(ROUNDS_A - 1);
    localparam logic [CW-1:0] LAST_B = CW'(ROUNDS_B - 1);
    localparam logic [3:0]    A_OFF  = 4'(12 - ROUNDS_A);
    localparam logic [3:0]    B_OFF  = 4'(12 - ROUNDS_B);

    phase_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [319:0]  s_q, s_d;
    logic [127:0]  sk_q, sk_d, a_q, a_d, c_q, c_d, t_q, t_d;
    logic [127:0]  pint_q, pint_d, p_q, p_d;
    logic          fin_q, fin_d, busy_q, busy_d, done_q, done_d, tag_ok_q, tag_ok_d;

    logic [319:0]  round_in, round_out;
    logic [3:0]    rc_idx;
    logic [7:0]    rc;
    logic [127:0]  tag_calc;
    logic          completing;

    // Pre-round XORs on the first round of each phase
    always_comb begin
        round_in = s_q;
        rc_idx   = 4'(cnt_q) + A_OFF;
        case (state_q)
            ST_ADATA: begin
                rc_idx = 4'(cnt_q) + B_OFF;
                if (cnt_q == '0) round_in[319:192] = s_q[319:192] ^ a_q;
            end
            ST_APAD: begin
                rc_idx = 4'(cnt_q) + B_OFF;
                if (cnt_q == '0) round_in[319:192] = s_q[319:192] ^ PAD128;
            end
            ST_CDATA: begin
                rc_idx = 4'(cnt_q) + B_OFF;
                if (cnt_q == '0) round_in[319:192] = c_q;
            end
            ST_FINAL: begin
                if (cnt_q == '0 && !fin_q) begin
                    round_in[319:192] = s_q[319:192] ^ PAD128;
                    round_in[191:64]  = s_q[191:64] ^ sk_q;
                end
            end
            default: ;
        endcase
    end

    assign rc = round_const(rc_idx);

    ascon_round u_round (
        .s_i  (round_in),
        .rc_i (rc),
        .s_o  (round_out)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s_d        = s_q;
        sk_d       = sk_q;
        a_d        = a_q;
        c_d        = c_q;
        t_d        = t_q;
        pint_d     = pint_q;
        p_d        = p_q;
        fin_d      = fin_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tag_ok_d   = tag_ok_q;
        completing = 1'b0;
        tag_calc   = s_q[127:0] ^ sk_q;

        case (state_q)
            ST_INIT: begin
                s_d   = round_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_A) begin
                    s_d[127:0] = round_out[127:0] ^ sk_q;
                    cnt_d      = '0;
                    state_d    = ST_ADATA;
                end
            end
            ST_ADATA: begin
                s_d   = round_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_B) begin
                    cnt_d   = '0;
                    state_d = ST_APAD;
                end
            end
            ST_APAD: begin
                s_d   = round_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_B) begin
                    s_d[0]  = round_out[0] ^ 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CDATA;
                end
            end
            ST_CDATA: begin
                if (cnt_q == '0) pint_d = s_q[319:192] ^ c_q;
                s_d   = round_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_B) begin
                    cnt_d   = '0;
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                if (fin_q) begin
                    // Rounds finished last edge; this edge publishes the result
                    completing = 1'b1;
                    tag_ok_d   = (tag_calc == t_q);
                    p_d        = (GATE_PT && (tag_calc != t_q)) ? '0 : pint_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    fin_d      = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    s_d   = round_out;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_A) begin
                        cnt_d = '0;
                        fin_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (start && (state_q == ST_IDLE || completing)) begin
            sk_d    = SK;
            a_d     = A;
            c_d     = C;
            t_d     = T;
            s_d     = {IV, SK, N};
            cnt_d   = '0;
            fin_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_INIT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            s_q      <= '0;
            sk_q     <= '0;
            a_q      <= '0;
            c_q      <= '0;
            t_q      <= '0;
            pint_q   <= '0;
            p_q      <= '0;
            fin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tag_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            sk_q     <= sk_d;
            a_q      <= a_d;
            c_q      <= c_d;
            t_q      <= t_d;
            pint_q   <= pint_d;
            p_q      <= p_d;
            fin_q    <= fin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tag_ok_q <= tag_ok_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign P      = p_q;
    assign tag_ok = tag_ok_q;

endmodule

// File: tb/tb_decrypt_1block_128a.sv
// tb/tb_decrypt_1block_128a.sv - bench for decrypt_1block_128a against an Ascon-128a model
module tb_decrypt_1block_128a;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic [127:0] SK, N, A, C, T;
    logic         busy, done, tag_ok;
    logic [127:0] P;
    logic         busy_ng, done_ng, tag_ok_ng;
    logic [127:0] P_ng;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    decrypt_1block_128a dut (
        .CLK(CLK), .RST(RST), .start(start), .SK(SK), .N(N), .A(A), .C(C), .T(T),
        .busy(busy), .done(done), .P(P), .tag_ok(tag_ok)
    );

    decrypt_1block_128a #(.GATE_PT(1'b0)) dut_ng (
        .CLK(CLK), .RST(RST), .start(start), .SK(SK), .N(N), .A(A), .C(C), .T(T),
        .busy(busy_ng), .done(done_ng), .P(P_ng), .tag_ok(tag_ok_ng)
    );

    // Reference model: table S-box applied per bit column
    typedef logic [0:4][63:0] st_t;

    localparam logic [4:0] SBOX_T [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam logic [7:0] RC_T [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    localparam logic [127:0] PAD = {8'h80, 120'h0};

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x};
        return d[n +: 64];
    endfunction

    function automatic st_t perm(input st_t s, input int nr);
        st_t r;
        logic [4:0] o;
        r = s;
        for (int k = 0; k < nr; k++) begin
            r[2][7:0] = r[2][7:0] ^ RC_T[12 - nr + k];
            for (int b = 0; b < 64; b++) begin
                o = SBOX_T[{r[0][b], r[1][b], r[2][b], r[3][b], r[4][b]}];
                {r[0][b], r[1][b], r[2][b], r[3][b], r[4][b]} = o;
            end
            r[0] = r[0] ^ rr(r[0], 19) ^ rr(r[0], 28);
            r[1] = r[1] ^ rr(r[1], 61) ^ rr(r[1], 39);
            r[2] = r[2] ^ rr(r[2], 1)  ^ rr(r[2], 6);
            r[3] = r[3] ^ rr(r[3], 10) ^ rr(r[3], 17);
            r[4] = r[4] ^ rr(r[4], 7)  ^ rr(r[4], 41);
        end
        return r;
    endfunction

    // dec=0: din is plaintext, dout ciphertext; dec=1: din is ciphertext, dout plaintext
    task automatic ascon_model(input logic [127:0] k, n, a, din, input bit dec,
                               output logic [127:0] dout, output logic [127:0] tag);
        st_t s;
        s = {64'h80800c0800000000, k, n};
        s = perm(s, 12);
        s[3:4] = s[3:4] ^ k;
        s[0:1] = s[0:1] ^ a;
        s = perm(s, 8);
        s[0:1] = s[0:1] ^ PAD;
        s = perm(s, 8);
        s[4][0] = ~s[4][0];
        dout = s[0:1] ^ din;
        s[0:1] = dec ? din : dout;
        s = perm(s, 8);
        s[0:1] = s[0:1] ^ PAD;
        s[2:3] = s[2:3] ^ k;
        s = perm(s, 12);
        tag = s[3:4] ^ k;
    endtask

    typedef struct {
        logic [127:0] sk, n, a, c, t;
        logic [127:0] exp_p, exp_p_ng;
        logic         exp_ok;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic mk(input logic [127:0] k, n, a, c, t, output vec_t v);
        logic [127:0] pd, tg;
        ascon_model(k, n, a, c, 1'b1, pd, tg);
        v.sk = k; v.n = n; v.a = a; v.c = c; v.t = t;
        v.exp_ok   = (tg == t);
        v.exp_p_ng = pd;
        v.exp_p    = v.exp_ok ? pd : 128'h0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        SK = v.sk; N = v.n; A = v.a; C = v.c; T = v.t;
    endtask

    task automatic scramble();
        SK = rnd128(); N = rnd128(); A = rnd128(); C = rnd128(); T = rnd128();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        drive(v);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk($sformatf("v%0d busy_after_accept", idx), 128'(busy), 128'(1'b1));
        scramble();
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 128'(lat), 128'd49);
        chk($sformatf("v%0d P", idx), P, v.exp_p);
        chk($sformatf("v%0d tag_ok", idx), 128'(tag_ok), 128'(v.exp_ok));
        chk($sformatf("v%0d P_ungated", idx), P_ng, v.exp_p_ng);
        chk($sformatf("v%0d busy_at_done", idx), 128'(busy), 128'(1'b0));
        @(posedge CLK); #1;
        chk($sformatf("v%0d done_one_cycle", idx), 128'(done), 128'(1'b0));
        chk($sformatf("v%0d P_held", idx), P, v.exp_p);
    endtask

    task automatic run_monitored(input vec_t v, input int p1, input int p2, input int rst_at,
                                 output int first_done, output int n_done);
        drive(v);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        first_done = 0;
        n_done = 0;
        for (int k = 1; k <= 70; k++) begin
            start = (k == p1 || k == p2);
            RST   = (k == rst_at);
            @(posedge CLK); #1;
            if (k == rst_at) begin
                chk("rst_mid busy", 128'(busy), 128'(1'b0));
                chk("rst_mid done", 128'(done), 128'(1'b0));
                chk("rst_mid P", P, 128'h0);
                chk("rst_mid tag_ok", 128'(tag_ok), 128'(1'b0));
            end
            if (done === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
        end
        start = 1'b0;
        RST   = 1'b0;
    endtask

    logic [127:0] base, c0, t0, k, n, a, p, c, t;
    int fd, nd, d1, d2;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; start = 1'b0;
        SK = '0; N = '0; A = '0; C = '0; T = '0;

        base = 128'h000102030405060708090a0b0c0d0e0f;
        ascon_model(base, base, base, base, 1'b0, c0, t0);
        mk(base, base, base, c0, t0, vecs[0]);
        mk(base, base, base, c0 ^ 128'h1, t0, vecs[1]);
        mk(base, base, base, c0, t0 ^ (128'h1 << 127), vecs[2]);
        mk(base, base, base ^ (128'h1 << 64), c0, t0, vecs[3]);
        for (int i = 4; i < 12; i++) begin
            k = rnd128(); n = rnd128(); a = rnd128(); p = rnd128();
            ascon_model(k, n, a, p, 1'b0, c, t);
            if (i % 4 == 0) c = c ^ (128'h1 << $urandom_range(127, 0));
            if (i % 4 == 2) t = t ^ (128'h1 << $urandom_range(127, 0));
            mk(k, n, a, c, t, vecs[i]);
        end

        repeat (3) @(posedge CLK);
        #1;
        chk("reset busy", 128'(busy), 128'(1'b0));
        chk("reset done", 128'(done), 128'(1'b0));
        chk("reset P", P, 128'h0);
        chk("reset tag_ok", 128'(tag_ok), 128'(1'b0));
        RST = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
            if (i == 0) chk("roundtrip P_is_original", P, base);
            if (i == 1) chk("cflip P_ungated_bit0_only", P_ng ^ base, 128'h1);
        end

        // start pulses while busy are ignored
        run_monitored(vecs[0], 5, 30, -1, fd, nd);
        chk("ignored_start first_done", 128'(fd), 128'd49);
        chk("ignored_start done_count", 128'(nd), 128'd1);
        chk("ignored_start P", P, base);
        chk("ignored_start tag_ok", 128'(tag_ok), 128'(1'b1));

        // reset mid-operation aborts without a done pulse
        run_monitored(vecs[5], -1, -1, 20, fd, nd);
        chk("rst_mid done_count", 128'(nd), 128'd0);
        run_vec(vecs[0], 100);

        // start held high across two operations
        drive(vecs[5]);
        start = 1'b1;
        @(posedge CLK); #1;
        drive(vecs[7]);
        d1 = 0; d2 = 0; nd = 0;
        for (int kk = 1; kk <= 110; kk++) begin
            start = (kk <= 49);
            @(posedge CLK); #1;
            if (done === 1'b1) begin
                nd++;
                if (d1 == 0) d1 = kk; else if (d2 == 0) d2 = kk;
                if (nd == 1) begin
                    chk("b2b first P", P, vecs[5].exp_p);
                    chk("b2b first tag_ok", 128'(tag_ok), 128'(vecs[5].exp_ok));
                    chk("b2b busy_reaccepted", 128'(busy), 128'(1'b1));
                end else begin
                    chk("b2b second P", P, vecs[7].exp_p);
                    chk("b2b second tag_ok", 128'(tag_ok), 128'(vecs[7].exp_ok));
                end
            end
        end
        start = 1'b0;
        chk("b2b first_done_cycle", 128'(d1), 128'd49);
        chk("b2b second_done_cycle", 128'(d2), 128'd98);
        chk("b2b done_count", 128'(nd), 128'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
